// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and
// a 128-bit block memory with a level-held request and a one-cycle ready pulse.
module dcache_direct_wb #(
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_ren,
    input  logic         proc_wen,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int TAG_W     = 28 - INDEX_W;
    localparam int NUM_LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];
    logic [27:0]          miss_blk_q, miss_blk_d;

    logic               req;
    logic               hit;
    logic [INDEX_W-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0]   req_tag, miss_tag;
    logic [1:0]         req_off;
    logic               wr_hit, wb_done, fill;

    assign req      = proc_ren | proc_wen;
    assign req_off  = proc_addr[1:0];
    assign req_idx  = proc_addr[INDEX_W+1:2];
    assign req_tag  = proc_addr[29:INDEX_W+2];
    assign miss_idx = miss_blk_q[INDEX_W-1:0];
    assign miss_tag = miss_blk_q[27:INDEX_W];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Read data is the addressed word whether or not the access hits.
    assign proc_rdata = data_q[req_idx][{req_off, 5'd0} +: 32];

    always_comb begin
        state_d    = state_q;
        miss_blk_d = miss_blk_q;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = miss_blk_q;
        mem_wdata  = data_q[miss_idx];
        wr_hit     = 1'b0;
        wb_done    = 1'b0;
        fill       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        wr_hit = proc_wen;
                    end else begin
                        proc_stall = 1'b1;
                        miss_blk_d = proc_addr[29:2];
                        state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                mem_write  = 1'b1;
                mem_addr   = {tag_q[miss_idx], miss_idx};
                proc_stall = 1'b1;
                if (mem_ready) begin
                    wb_done = 1'b1;
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_read   = 1'b1;
                proc_stall = 1'b1;
                if (mem_ready) begin
                    fill    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            miss_blk_q <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            miss_blk_q <= miss_blk_d;
            if (wr_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if (wb_done) begin
                dirty_q[miss_idx] <= 1'b0;
            end
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
                dirty_q[miss_idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            data_q[req_idx][{req_off, 5'd0} +: 32] <= proc_wdata;
        end
        if (fill) begin
            data_q[miss_idx] <= mem_rdata;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed bench for dcache_direct_wb: vector table run through a small block
// memory responder, plus a hand-written reset-during-refill sequence.
module tb_dcache_direct_wb;
    logic         clk;
    logic         rst_n;
    logic         proc_ren;
    logic         proc_wen;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    dcache_direct_wb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_ren   (proc_ren),
        .proc_wen   (proc_wen),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        w;
        logic [29:0] a;
        logic [31:0] d;
        int          lat;
        int          ecyc;
        int          ewb;
        int          efill;
        logic        chkrd;
        logic [31:0] erd;
    } vec_t;

    vec_t         tv [16];
    int           nvec;
    int           nfail;
    int           bad_proto;
    int           unstable;
    logic [127:0] mem_blk [256];
    logic [27:0]  last_wb_addr;
    logic [27:0]  last_fill_addr;
    logic [127:0] last_wb_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one request and act as the memory until the cache releases the stall.
    task automatic do_access(input vec_t v, output int cyc, output int nwb, output int nfill);
        int           wait_cnt;
        logic         in_txn;
        logic [27:0]  t_addr;
        logic [127:0] t_wdata;
        wait_cnt   = 0;
        in_txn     = 1'b0;
        t_addr     = '0;
        t_wdata    = '0;
        cyc        = 0;
        nwb        = 0;
        nfill      = 0;
        proc_ren   = v.r;
        proc_wen   = v.w;
        proc_addr  = v.a;
        proc_wdata = v.d;
        #1;
        while (proc_stall && cyc < 200) begin
            if (mem_read && mem_write) bad_proto++;
            if (mem_read || mem_write) begin
                if (!in_txn) begin
                    in_txn  = 1'b1;
                    t_addr  = mem_addr;
                    t_wdata = mem_wdata;
                end else if (mem_addr !== t_addr || (mem_write && mem_wdata !== t_wdata)) begin
                    unstable++;
                end
                if (wait_cnt >= v.lat) begin
                    mem_ready = 1'b1;
                    if (mem_write) begin
                        mem_blk[mem_addr[7:0]] = mem_wdata;
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                        nwb++;
                    end else begin
                        mem_rdata = mem_blk[mem_addr[7:0]];
                        last_fill_addr = mem_addr;
                        nfill++;
                    end
                    wait_cnt = 0;
                    in_txn   = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int i);
        int cyc;
        int nwb;
        int nfill;
        do_access(tv[i], cyc, nwb, nfill);
        chk($sformatf("v%0d_stall_cycles", i), 128'(cyc), 128'(tv[i].ecyc));
        chk($sformatf("v%0d_writebacks", i), 128'(nwb), 128'(tv[i].ewb));
        chk($sformatf("v%0d_fills", i), 128'(nfill), 128'(tv[i].efill));
        if (tv[i].chkrd) chk($sformatf("v%0d_rdata", i), 128'(proc_rdata), 128'(tv[i].erd));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //          ren   wen   addr     wdata         lat ecyc wb fill chk  rdata
        tv[0]  = '{1'b1, 1'b0, 30'h010, 32'h0,        4,  6,   0, 1, 1'b1, 32'h11};
        tv[1]  = '{1'b1, 1'b0, 30'h012, 32'h0,        0,  0,   0, 0, 1'b1, 32'h33};
        tv[2]  = '{1'b0, 1'b1, 30'h011, 32'hDEADBEEF, 0,  0,   0, 0, 1'b0, 32'h0};
        tv[3]  = '{1'b1, 1'b0, 30'h111, 32'h0,        2,  7,   1, 1, 1'b1, 32'h4401};
        tv[4]  = '{1'b1, 1'b0, 30'h011, 32'h0,        0,  2,   0, 1, 1'b1, 32'hDEADBEEF};
        tv[5]  = '{1'b0, 1'b1, 30'h020, 32'h5,        1,  3,   0, 1, 1'b0, 32'h0};
        tv[6]  = '{1'b1, 1'b0, 30'h020, 32'h0,        0,  0,   0, 0, 1'b1, 32'h5};
        tv[7]  = '{1'b1, 1'b0, 30'h021, 32'h0,        0,  0,   0, 0, 1'b1, 32'h801};
        tv[8]  = '{1'b1, 1'b0, 30'h040, 32'h0,        1,  5,   1, 1, 1'b1, 32'h1000};
        tv[9]  = '{1'b1, 1'b1, 30'h042, 32'hCAFEF00D, 0,  0,   0, 0, 1'b0, 32'h0};
        tv[10] = '{1'b1, 1'b0, 30'h042, 32'h0,        0,  0,   0, 0, 1'b1, 32'hCAFEF00D};
        tv[11] = '{1'b1, 1'b0, 30'h060, 32'h0,        0,  3,   1, 1, 1'b1, 32'h1800};
        tv[12] = '{1'b1, 1'b0, 30'h080, 32'h0,        20, 22,  0, 1, 1'b1, 32'h2000};
        tv[13] = '{1'b1, 1'b0, 30'h100, 32'h0,        0,  2,   0, 1, 1'b1, 32'h4000};
        tv[14] = '{1'b1, 1'b0, 30'h010, 32'h0,        0,  2,   0, 1, 1'b1, 32'h11};
        tv[15] = '{1'b1, 1'b0, 30'h011, 32'h0,        0,  0,   0, 0, 1'b1, 32'hDEADBEEF};

        for (int b = 0; b < 256; b++) begin
            mem_blk[b] = {24'(b), 8'h03, 24'(b), 8'h02, 24'(b), 8'h01, 24'(b), 8'h00};
        end
        mem_blk[4] = {32'h44, 32'h33, 32'h22, 32'h11};

        nvec = 0; nfail = 0; bad_proto = 0; unstable = 0;
        last_wb_addr = '0; last_fill_addr = '0; last_wb_data = '0;
        rst_n = 1'b0; proc_ren = 1'b0; proc_wen = 1'b0;
        proc_addr = '0; proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 128'(proc_stall), 128'(0));
        chk("reset_mem_read", 128'(mem_read), 128'(0));
        chk("reset_mem_write", 128'(mem_write), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i <= 12; i++) begin
            run_vec(i);
            if (i == 0) chk("cold_fill_addr", 128'(last_fill_addr), 128'(28'h4));
            if (i == 3) begin
                chk("evict_wb_addr", 128'(last_wb_addr), 128'(28'h4));
                chk("evict_wb_data", last_wb_data, {32'h44, 32'h33, 32'hDEADBEEF, 32'h11});
                chk("evict_fill_addr", 128'(last_fill_addr), 128'(28'h44));
            end
            if (i == 8) begin
                chk("wmiss_wb_addr", 128'(last_wb_addr), 128'(28'h8));
                chk("wmiss_wb_word0", 128'(last_wb_data[31:0]), 128'(32'h5));
            end
            if (i == 11) begin
                chk("rw_wb_addr", 128'(last_wb_addr), 128'(28'h10));
                chk("rw_wb_word2", 128'(last_wb_data[95:64]), 128'(32'hCAFEF00D));
            end
        end
        chk("backpressure_stability", 128'(unstable), 128'(0));

        // Reset arrives while a refill is outstanding.
        proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 30'h100;
        #1;
        chk("rst_seq_miss_stall", 128'(proc_stall), 128'(1));
        @(posedge clk);
        @(negedge clk);
        chk("rst_seq_alloc_read", 128'(mem_read), 128'(1));
        chk("rst_seq_alloc_addr", 128'(mem_addr), 128'(28'h40));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_seq_read_dropped", 128'(mem_read), 128'(0));
        chk("rst_seq_no_write", 128'(mem_write), 128'(0));
        chk("rst_seq_req_misses", 128'(proc_stall), 128'(1));
        proc_ren = 1'b0;
        #1;
        chk("rst_seq_idle_stall", 128'(proc_stall), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("stray_ready_read", 128'(mem_read), 128'(0));
        chk("stray_ready_write", 128'(mem_write), 128'(0));
        chk("stray_ready_stall", 128'(proc_stall), 128'(0));

        for (int i = 13; i <= 15; i++) begin
            run_vec(i);
        end
        proc_ren = 1'b0;
        proc_wen = 1'b0;
        chk("protocol_read_write_exclusive", 128'(bad_proto), 128'(0));
        chk("request_stability", 128'(unstable), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/dcache_direct_wb.md
Name: dcache_direct_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache; the responder on the core's D-cache port (ren/wen/addr/wdata in, stall/rdata out).
- Sits between the pipeline's MEM stage and a slow main memory. Memory is reached through a 4-word (128-bit) block interface with a level-held request and a one-cycle ready pulse.
- Hits complete with zero stall. A miss stalls the core until the block is written back (if dirty) and refilled.

Parameters:
- INDEX_W, 3, index bits; NUM_LINES = 2^INDEX_W (default 8 lines).
- TAG_W, 28-INDEX_W, tag bits, derived; not to be overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- proc_ren  in  1  word read request.
- proc_wen  in  1  word write request.
- proc_addr  in  30  word address: [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- proc_wdata  in  32  write data.
- proc_rdata  out  32  read data; valid when proc_ren=1 and proc_stall=0.
- proc_stall  out  1  hold request; core freezes EX/MEM.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block write-back request.
- mem_addr  out  28  block address, i.e. proc_addr[29:2] form.
- mem_wdata  out  128  victim block; word0 in [31:0].
- mem_rdata  in  128  fill block; word0 in [31:0].
- mem_ready  in  1  one-cycle pulse; completes the current mem_read or mem_write.

Behaviour:
- Storage per line: valid, dirty, tag[TAG_W], data[128]. Registered; no SRAM macro.
- req = proc_ren | proc_wen. If both are high, treat as a write. hit = valid[idx] & (tag[idx]==addr tag).
- States:
  - IDLE:
    - req & hit: proc_stall=0.
    - Read hit: proc_rdata = selected word, combinational, same cycle.
    - Write hit: word updated and dirty set at this clock edge.
    - req & miss: proc_stall=1. Latch proc_addr into miss_addr. Next state WRITEBACK if valid&dirty, else ALLOCATE.
    - No req: proc_stall=0.
  - WRITEBACK:
    - mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim data. proc_stall=1.
    - On mem_ready: dirty cleared; go to ALLOCATE.
  - ALLOCATE:
    - mem_read=1, mem_addr=miss_addr[29:2]. proc_stall=1.
    - On mem_ready: data<=mem_rdata, tag<=miss tag, valid<=1, dirty<=0; go to IDLE.
- After refill, IDLE re-evaluates the held request as a hit with stall=0. A write miss therefore merges proc_wdata on that hit cycle.
- mem_read/mem_write are decoded from state only: never both high, and 0 in IDLE. They are held stable until mem_ready. mem_addr and mem_wdata are stable while requested.
- Latency:
  - Clean miss detected in cycle T, memory ready k cycles after ALLOCATE entry: stall is high for T..T+k; proc_stall=0 at T+k+1.
  - Dirty miss adds the write-back wait before ALLOCATE.
- mem_ready while in IDLE: ignored.
- Request dropped or changed mid-miss: the in-flight memory transaction completes and the line fills with miss_addr. IDLE then services whatever request is present.
- Reset (rst_n=0 at any edge, including mid-WRITEBACK/ALLOCATE): state<=IDLE, all valid and dirty <=0, miss_addr<=0. Tag/data are don't-care.
  - mem_read=0 and mem_write=0 from the following cycle. proc_stall=0 unless a request is present, in which case the request misses.
  - A pending memory transaction is abandoned; the memory model must tolerate this.
- proc_rdata is don't-care while stalled or with no read request. Drive it as the indexed word (no X).

Test Plan:
- Cold read: after reset, ren addr 0x00000010 -> stall=1, mem_read=1, mem_addr=0x0000004, no mem_write. mem_ready with mem_rdata word0..3 = 0x11,0x22,0x33,0x44 after 4 cycles -> next cycle stall=0, rdata=0x11. Read addr 0x00000012 -> stall=0 immediately, rdata=0x33.
- Write hit then eviction: write 0xDEADBEEF to 0x00000011 -> no stall. Then ren addr 0x00000111 (same index 4, different tag):
  - WRITEBACK first: mem_write=1, mem_addr=0x0000004, mem_wdata=0x44_33_DEADBEEF_11 (word order 3..0).
  - Then ALLOCATE with mem_addr=0x0000044.
- Write miss on clean line: wen addr 0x00000020 data 0x5 -> mem_read only. After fill, stall drops. A later read returns 0x5. A subsequent conflicting miss must write back (dirty=1).
- Simultaneous ren=wen=1 on hit -> behaves as write: memory word updated, no stall, dirty set.
- Reset mid-ALLOCATE: assert rst_n=0 one cycle before mem_ready -> mem_read=0 next cycle. The same address re-requested misses again (valid cleared).
- Memory backpressure: mem_ready delayed 20 cycles -> stall held 21+ cycles. mem_addr and mem_wdata constant throughout. Exactly one fill occurs.
